mem_scheduler: RTL
==================

// Module: mem_scheduler
// PURPOSE
//  Two-port scheduler between the CPU instruction and data memory ports and the single SoC
//  memory bus that feeds the address decoder. Buffers one request per port and grants with
//  data priority plus an anti-starvation limit. Keeps at most one bus transaction outstanding
//  and closes hung transactions with an error response after a watchdog timeout.
// PARAMETERS
//  timeout_cycles  1024  cycles in WAIT/DRAIN without mem_ready before timeout (>=2)
//  starve_limit    4     consecutive data grants while an instr request waits before instr wins
// PORTS
//  clock      in   1              system clock; single clock domain, all state on posedge
//  reset      in   1              asynchronous, active-low; clears all state immediately
//  imem_in    in   mem_in_type    instruction request (mem_valid is a 1-cycle pulse)
//  imem_out   out  mem_out_type   instruction response
//  dmem_in    in   mem_in_type    data request (mem_valid is a 1-cycle pulse)
//  dmem_out   out  mem_out_type   data response
//  mem_in     out  mem_in_type    request to the address decoder / bus
//  mem_out    in   mem_out_type   response from the address decoder / bus
// BEHAVIOUR
//  Reset: state=IDLE, both slots empty, starve_cnt=0, wdog=0; mem_in=init_mem_in,
//   imem_out=dmem_out=init_mem_out (mem_ready=0, mem_error=0, mem_rdata=0).
//  Capture: a valid pulse on a port loads that port's slot the same edge. A pulse while the
//   slot is full, or while that port is granted, is ignored (one outstanding per port).
//  States:
//   IDLE : no slot full -> stay. Otherwise pick winner, go to ISSUE. Both full: data wins
//          unless starve_cnt==starve_limit, then instr wins. Data win with instr full ->
//          starve_cnt+1 (saturates). Any instr grant -> starve_cnt=0.
//   ISSUE: mem_in = winner's slot with mem_valid=1, for exactly this cycle; slot cleared;
//          wdog=0 -> WAIT. A mem_ready in this cycle is accepted as in WAIT.
//   WAIT : mem_in.mem_valid=0. mem_ready=1 -> forward mem_out to granted port's out
//          combinationally, same cycle (rdata, error, ready); other port's out stays init.
//          Go to IDLE. Else wdog+1. When wdog reaches timeout_cycles-1 -> granted port gets
//          a registered response next cycle: ready=1, error=1, rdata=0. wdog=0 -> DRAIN.
//   DRAIN: Waits for the late response. mem_ready -> discarded, no port output -> IDLE.
//          wdog reaching timeout_cycles-1 -> IDLE. Late response is never forwarded.
//  Latency: request pulse at cycle t -> mem_in.mem_valid at t+2 (port idle, no contention).
//   Bus mem_ready at cycle u -> port mem_ready at u. Next ISSUE no earlier than u+2.
//  Simultaneous: a response and a new pulse from the same port in one cycle -> response
//   delivered and new request captured (the slot frees as grant ends). A pulse on each port
//   in one cycle -> both captured, data granted first (subject to starve rule).
//  mem_ready arriving in IDLE (stray) -> ignored, no port output.
//  Reset mid-transaction: everything returns to reset values at once. Any downstream
//   response after reset release arrives in IDLE and is ignored.
//  Widths: wdog is $clog2(timeout_cycles)+1 bits, unsigned, no wrap while counting.
//   starve_cnt is $clog2(starve_limit+1) bits.
// STRUCTURE
//  wires package: sched_state_type enum {IDLE, ISSUE, WAIT, DRAIN} and
//   sched_grant_type {GRANT_I, GRANT_D}.
//  configure package: sched_timeout_cycles, sched_starve_limit defaults, passed as parameters
//   at the soc instance in place of the current arbiter.
//  Sub-module mem_req_slot: 1-entry mem_in_type buffer with load/clear/full. Instanced twice.
//  The top holds the FSM, starve counter, watchdog, and response steering/error register.
// TESTING
//  1 dmem read pulse addr 0x00010000, bus ready at +3 with rdata 0xDEADBEEF -> mem_in valid at
//    t+2 for 1 cycle; dmem_out ready=1, rdata=0xDEADBEEF in the bus-ready cycle; imem_out idle.
//  2 imem and dmem pulses in the same cycle -> data issued first; instr issued 2 cycles after
//    the data response; each response steered only to its own port.
//  3 instr held pending while 5 back-to-back data requests arrive (starve_limit=4) -> grant
//    order D,D,D,D,I,D; starve_cnt returns to 0 after the I grant.
//  4 bus never readies (timeout_cycles=16) -> port gets ready=1, error=1, rdata=0 exactly 16
//    cycles after ISSUE. A late ready in DRAIN is not forwarded, then IDLE.
//  5 second dmem pulse while dmem is granted -> ignored, exactly one data transaction on bus.
//  6 assert reset during WAIT, bus readies 2 cycles after release -> all outputs init, stray
//    ready ignored, a following fresh imem request completes normally.

Source files
------------

// File: rtl/mem_scheduler_pkg.sv
// Shared types and defaults for the instruction/data memory scheduler.
// Bus request/response structs, FSM state and grant encodings, configuration defaults.
package mem_scheduler_pkg;

  localparam int unsigned sched_timeout_cycles = 1024;
  localparam int unsigned sched_starve_limit   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} sched_state_type;
  typedef enum logic       {GRANT_I, GRANT_D}         sched_grant_type;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;
  localparam mem_out_type err_mem_out  = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: '0};

endpackage

// File: rtl/mem_req_slot.sv
// One-entry request buffer for a single CPU memory port.
// Load has priority over clear so a request arriving as the grant ends is kept.
module mem_req_slot
  import mem_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic       clear_i,
  input  mem_in_type data_i,
  output mem_in_type data_o,
  output logic       full_o
);

  mem_in_type data_q;
  logic       full_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= init_mem_in;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates CPU instruction/data requests onto the single SoC memory bus, one transaction
// outstanding, data priority with anti-starvation, and watchdog-closed hung transactions.
module mem_scheduler
  import mem_scheduler_pkg::*;
#(
  parameter int unsigned timeout_cycles = sched_timeout_cycles,
  parameter int unsigned starve_limit   = sched_starve_limit
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam int unsigned WDW = $clog2(timeout_cycles) + 1;
  localparam int unsigned SCW = $clog2(starve_limit + 1);

  sched_state_type state_q;
  sched_grant_type grant_q;
  logic [SCW-1:0]  starve_q;
  logic [WDW-1:0]  wdog_q;
  mem_in_type      mem_in_q;
  logic            err_q;

  mem_in_type i_data, d_data, win_req;
  logic       i_full, d_full, i_load, d_load, i_clear, d_clear;
  logic       resp_ok, port_busy, pick_d, pick_i;

  mem_req_slot u_islot (
    .clock   (clock),
    .reset   (reset),
    .load_i  (i_load),
    .clear_i (i_clear),
    .data_i  (imem_in),
    .data_o  (i_data),
    .full_o  (i_full)
  );

  mem_req_slot u_dslot (
    .clock   (clock),
    .reset   (reset),
    .load_i  (d_load),
    .clear_i (d_clear),
    .data_i  (dmem_in),
    .data_o  (d_data),
    .full_o  (d_full)
  );

  // The granted port may capture again in the very cycle its response is delivered.
  always_comb begin
    resp_ok   = (state_q == ISSUE || state_q == WAIT) && mem_out.mem_ready;
    port_busy = (state_q == ISSUE || state_q == WAIT) && !mem_out.mem_ready;
    i_clear   = (state_q == ISSUE) && (grant_q == GRANT_I);
    d_clear   = (state_q == ISSUE) && (grant_q == GRANT_D);
    i_load    = imem_in.mem_valid && (!i_full || i_clear) && !(port_busy && grant_q == GRANT_I);
    d_load    = dmem_in.mem_valid && (!d_full || d_clear) && !(port_busy && grant_q == GRANT_D);

    pick_d    = d_full && (!i_full || starve_q != SCW'(starve_limit));
    pick_i    = i_full && !pick_d;
    win_req   = pick_d ? d_data : i_data;
    win_req.mem_valid = 1'b1;

    imem_out = init_mem_out;
    dmem_out = init_mem_out;
    if (err_q) begin
      if (grant_q == GRANT_I) imem_out = err_mem_out;
      else                    dmem_out = err_mem_out;
    end else if (resp_ok) begin
      if (grant_q == GRANT_I) imem_out = mem_out;
      else                    dmem_out = mem_out;
    end
  end

  assign mem_in = mem_in_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= GRANT_I;
      starve_q <= '0;
      wdog_q   <= '0;
      mem_in_q <= init_mem_in;
      err_q    <= 1'b0;
    end else begin
      mem_in_q <= init_mem_in;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            grant_q  <= GRANT_D;
            mem_in_q <= win_req;
            state_q  <= ISSUE;
            if (i_full) starve_q <= starve_q + 1'b1;
          end else if (pick_i) begin
            grant_q  <= GRANT_I;
            mem_in_q <= win_req;
            state_q  <= ISSUE;
            starve_q <= '0;
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= mem_out.mem_ready ? IDLE : WAIT;
        end
        WAIT: begin
          if (mem_out.mem_ready) begin
            state_q <= IDLE;
          end else if (wdog_q == WDW'(timeout_cycles - 2)) begin
            err_q   <= 1'b1;
            wdog_q  <= '0;
            state_q <= DRAIN;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        DRAIN: begin
          if (mem_out.mem_ready || wdog_q == WDW'(timeout_cycles - 2)) begin
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
